sensor_window_counter: RTL and testbench
========================================

# sensor_window_counter

Multi-channel gated-window edge counter for the ring-oscillator sensor tiles. It counts rising edges on NCH sensor outputs over a programmable window of clk cycles and latches the per-channel results. The results are then read back byte-wise over the 8-bit dedicated-output path of the tile top. It replaces the single-channel fixed-window sensor counter, adding channel count, window length, saturation/overflow flags and a continuous mode.

## Interface
- NCH, 4, number of sensor channels (1..8)
- CNT_W, 16, counter width per channel; a multiple of 8, 8..32
- WIN_W, 10, width of the window-length input
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high; one clock domain, no other reset
- sense_i  in  NCH  raw sensor oscillator outputs, asynchronous to clk
- start_i  in  1  start a measurement (sampled in IDLE only)
- cont_i  in  1  continuous mode; re-arms after each window while high
- win_len_i  in  WIN_W  window length in clk cycles; sampled in ARM
- busy_o  in  1  high in any state other than IDLE
- done_o  out  1  one-cycle pulse when new results are latched
- ovf_o  out  NCH  per-channel saturation flag of the latched window
- rd_ch_i  in  max(1,$clog2(NCH))  readback channel select
- rd_byte_i  in  max(1,$clog2(CNT_W/8))  readback byte select; 0 is the LSB
- rd_data_o  out  8  selected result byte, registered

Correction to the list above: busy_o is an output (out 1), not an input.

## Operation
- FSM states and transitions:
  - IDLE: if start_i is high, go to ARM.
  - ARM (1 cycle):
    - clear the live counters and live overflow bits;
    - load the window down-counter with win_len_i;
    - load the edge-detect register with the current synced sense value, so no spurious edge is counted;
    - go to COUNT, or go directly to LATCH if win_len_i==0.
  - COUNT: lasts exactly win_len_i cycles. Each cycle, every channel whose synced sample goes 0->1 (previous 0, current 1) increments. Go to LATCH when the down-counter reaches 1.
  - LATCH (1 cycle):
    - copy the live counters to the result registers and the live overflow bits to ovf_o;
    - pulse done_o;
    - go to ARM if cont_i is high, else go to IDLE.
- Saturation: a live counter stays at 2^CNT_W-1 on further edges and sets its live overflow bit. Overflow is sticky within the window.
- start_i is ignored outside IDLE. cont_i is sampled only in LATCH; dropping it stops after the current window.
- Readback: rd_data_o <= result[rd_ch_i][8*rd_byte_i +: 8].
  - rd_ch_i >= NCH or an out-of-range byte select gives 0x00.
  - Results change only in LATCH.
- Reset values:
  - state IDLE;
  - all counters, results, ovf_o, rd_data_o, done_o and busy_o are 0;
  - edge-detect and synchronizer flops are 0.
- Reset mid-window: the window is aborted, nothing is latched, no done_o pulse.

## Timing
- From start_i high in IDLE: ARM on cycle +1, COUNT on cycles +2..+1+W (W = win_len_i), LATCH and done_o on cycle +2+W.
- For W==0, done_o comes on cycle +2 with all counts 0.
- Continuous mode: back-to-back windows have a period of W+2 cycles. Edges during LATCH and ARM are not counted.
- Edge-to-count latency: 3 cycles with sync, 1 cycle without.
- Maximum countable sense frequency is clk/2 (one rising edge per 2 synced samples).
- Readback latency is 1 cycle. rd_data_o reflects the new results in the cycle after the done_o pulse.

## Configuration
- SENSOR_SYNC_EN:
  - Defined: each sense_i bit passes a 2-flop synchronizer before edge detect.
  - Undefined: sense_i feeds edge detect directly. This is only for benches and for sensors already in the clk domain.
- The FSM and readback are identical either way; only the latency shifts by 2 cycles.

## Structure
- Package sensor_pkg:
  - FSM state enum (IDLE, ARM, COUNT, LATCH);
  - a function computing the select widths;
  - the saturation constant per CNT_W.
- One sub-module, sensor_edge_chan, instantiated NCH times. It contains:
  - the optional synchronizer;
  - edge detect;
  - the saturating counter;
  - the overflow bit.
- The top holds the FSM, window counter, result registers and readback mux.

## Test plan
- Reset: after rst, every output is 0 and busy_o is 0. Read all channels and bytes -> 0x00.
- Single shot, W=100, sense[0]=clk/4, sense[1] tied low: done_o at cycle +102, ch0=25±1, ch1=0, busy_o low after LATCH.
- Saturation with CNT_W=8, W=600, sense=clk/2: result 0xFF, ovf_o bit set. A following window at clk/8 clears ovf_o.
- Continuous mode, W=10: done_o pulses every 12 cycles. Drop cont_i -> exactly one more pulse, then IDLE.
- Boundary cases:
  - W=0 -> done_o at +2 with zero counts;
  - start_i during COUNT is ignored;
  - rd_ch_i=NCH reads 0x00.
- Reset mid-window at cycle +50 of a 100-cycle window: no done_o, results are 0, and a fresh start produces correct counts.

Source files
------------

// File: rtl/sensor_pkg.sv
// Shared types and helpers for sensor_window_counter: FSM states, select widths, saturation value.
package sensor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_COUNT = 2'd2,
    ST_LATCH = 2'd3
  } state_e;

  localparam int unsigned MAX_CNT_W = 32;

  // Select width for n items; never narrower than one bit.
  function automatic int sel_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic logic [MAX_CNT_W-1:0] sat_val(input int unsigned w);
    return (w >= MAX_CNT_W) ? {MAX_CNT_W{1'b1}} : ((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/sensor_edge_chan.sv
// One sensor channel: optional 2-flop synchronizer (SENSOR_SYNC_EN), rising-edge detect,
// saturating edge counter and sticky overflow bit.
module sensor_edge_chan
  import sensor_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sense_i,
  input  logic             clr_i,
  input  logic             cnt_en_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             ovf_o
);

  localparam logic [CNT_W-1:0] SAT = CNT_W'(sat_val(CNT_W));

  logic             synced_s;
  logic             prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

`ifdef SENSOR_SYNC_EN
  logic [1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[0], sense_i};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign synced_s = sync_q[1];
`else
  assign synced_s = sense_i;
`endif

  // prev tracks the synced sample every cycle, so after ARM no stale edge can be seen.
  always_comb begin
    prev_d = synced_s;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    if (clr_i) begin
      cnt_d = {CNT_W{1'b0}};
      ovf_d = 1'b0;
    end else if (cnt_en_i && synced_s && !prev_q) begin
      if (cnt_q == SAT) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = cnt_q;
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= 1'b0;
      cnt_q  <= {CNT_W{1'b0}};
      ovf_q  <= 1'b0;
    end else begin
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end

  assign cnt_o = cnt_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/sensor_window_counter.sv
// Multi-channel gated-window edge counter with latched results and byte-wise readback.
// Define SENSOR_SYNC_EN to put a 2-flop synchronizer on every sense_i bit.
module sensor_window_counter
  import sensor_pkg::*;
#(
  parameter  int NCH    = 4,
  parameter  int CNT_W  = 16,
  parameter  int WIN_W  = 10,
  localparam int CH_W   = sel_w(NCH),
  localparam int BYTE_W = sel_w(CNT_W / 8)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    sense_i,
  input  logic              start_i,
  input  logic              cont_i,
  input  logic [WIN_W-1:0]  win_len_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [NCH-1:0]    ovf_o,
  input  logic [CH_W-1:0]   rd_ch_i,
  input  logic [BYTE_W-1:0] rd_byte_i,
  output logic [7:0]        rd_data_o
);

  localparam int NBYTE = CNT_W / 8;

  state_e                    state_q, state_d;
  logic [WIN_W-1:0]          win_q, win_d;
  logic [NCH-1:0][CNT_W-1:0] res_q, res_d;
  logic [NCH-1:0]            ovf_q, ovf_d;
  logic                      done_q, done_d;
  logic                      busy_q, busy_d;
  logic [7:0]                rd_data_q, rd_data_d;
  logic [NCH-1:0][CNT_W-1:0] live_cnt_s;
  logic [NCH-1:0]            live_ovf_s;
  logic                      clr_s, cnt_en_s;

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    sensor_edge_chan #(
      .CNT_W(CNT_W)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .sense_i  (sense_i[g]),
      .clr_i    (clr_s),
      .cnt_en_i (cnt_en_s),
      .cnt_o    (live_cnt_s[g]),
      .ovf_o    (live_ovf_s[g])
    );
  end

  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    res_d    = res_q;
    ovf_d    = ovf_q;
    clr_s    = 1'b0;
    cnt_en_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_ARM;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ARM: begin
        clr_s = 1'b1;
        win_d = win_len_i;
        if (win_len_i == {WIN_W{1'b0}}) begin
          state_d = ST_LATCH;
        end else begin
          state_d = ST_COUNT;
        end
      end
      ST_COUNT: begin
        cnt_en_s = 1'b1;
        if (win_q <= WIN_W'(1)) begin
          state_d = ST_LATCH;
        end else begin
          win_d = win_q - WIN_W'(1);
        end
      end
      ST_LATCH: begin
        res_d = live_cnt_s;
        ovf_d = live_ovf_s;
        if (cont_i) begin
          state_d = ST_ARM;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    done_d = (state_d == ST_LATCH);
    busy_d = (state_d != ST_IDLE);
  end

  // Readback muxes the next-cycle results so fresh data is visible right after done_o.
  always_comb begin
    rd_data_d = 8'h00;
    for (int c = 0; c < NCH; c++) begin
      for (int b = 0; b < NBYTE; b++) begin
        rd_data_d = rd_data_d |
                    (((int'(rd_ch_i) == c) && (int'(rd_byte_i) == b)) ? res_d[c][8*b +: 8] : 8'h00);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      win_q     <= {WIN_W{1'b0}};
      res_q     <= {(NCH*CNT_W){1'b0}};
      ovf_q     <= {NCH{1'b0}};
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      rd_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      res_q     <= res_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign ovf_o     = ovf_q;
  assign rd_data_o = rd_data_q;

endmodule

// File: tb/tb_sensor_window_counter.sv
// Scoreboard bench for sensor_window_counter: two instances (16-bit and 8-bit counters)
// share random sense waveforms; expected counts come from edge counting over the window.
module tb_sensor_window_counter;

  localparam int NCH   = 3;
  localparam int WIN_W = 10;
  localparam int MAXC  = 40000;
`ifdef SENSOR_SYNC_EN
  localparam int D = 2;
`else
  localparam int D = 0;
`endif

  typedef struct packed {
    int                   done_cyc;
    logic [NCH-1:0][15:0] n;
  } win_t;

  typedef struct packed {
    int         at;
    logic [7:0] a;
    logic [7:0] b;
  } rd_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [NCH-1:0]   sense;
  logic             start, cont;
  logic [WIN_W-1:0] win_len;
  logic [1:0]       rd_ch;
  logic [0:0]       rd_byte;
  logic             busy_a, done_a, busy_b, done_b;
  logic [NCH-1:0]   ovf_a, ovf_b;
  logic [7:0]       rd_a, rd_b;

  logic [NCH-1:0]       sense_arr [MAXC];
  int                   cyc = 0;
  int                   n_vec = 0;
  int                   n_err = 0;
  win_t                 exp_q [$];
  rd_t                  rd_q [$];
  logic [NCH-1:0][15:0] last_n;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  sensor_window_counter #(.NCH(NCH), .CNT_W(16), .WIN_W(WIN_W)) dut_a (
    .clk(clk), .rst(rst), .sense_i(sense), .start_i(start), .cont_i(cont),
    .win_len_i(win_len), .busy_o(busy_a), .done_o(done_a), .ovf_o(ovf_a),
    .rd_ch_i(rd_ch), .rd_byte_i(rd_byte), .rd_data_o(rd_a)
  );

  sensor_window_counter #(.NCH(NCH), .CNT_W(8), .WIN_W(WIN_W)) dut_b (
    .clk(clk), .rst(rst), .sense_i(sense), .start_i(start), .cont_i(cont),
    .win_len_i(win_len), .busy_o(busy_b), .done_o(done_b), .ovf_o(ovf_b),
    .rd_ch_i(rd_ch), .rd_byte_i(rd_byte), .rd_data_o(rd_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic pat(input int mode, input int t);
    case (mode)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return t[0];
      3:       return t[1];
      4:       return t[2];
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic fill(input int from, input int to, input int ch, input int mode);
    for (int t = from; t <= to && t < MAXC; t++) sense_arr[t][ch] = pat(mode, t);
  endtask

  // Rising edges of the synced sample seen during the W counting cycles of a window.
  function automatic int edges(input int s, input int w, input int ch);
    int n = 0;
    for (int t = s + 2; t <= s + 1 + w; t++)
      if (sense_arr[t-D][ch] && !sense_arr[t-1-D][ch]) n++;
    return n;
  endfunction

  function automatic logic [7:0] exp_byte(input logic [NCH-1:0][15:0] n, input int ch,
                                          input int b, input int cw);
    int sat, v;
    if (ch >= NCH || b >= cw / 8) return 8'h00;
    sat = (1 << cw) - 1;
    v = (int'(n[ch]) > sat) ? sat : int'(n[ch]);
    return 8'(v >> (8 * b));
  endfunction

  function automatic logic [NCH-1:0] exp_ovf(input logic [NCH-1:0][15:0] n, input int cw);
    logic [NCH-1:0] o;
    for (int ch = 0; ch < NCH; ch++) o[ch] = (int'(n[ch]) > ((1 << cw) - 1));
    return o;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    if (cyc >= MAXC) begin
      $display("FAIL cycle_budget: got %0d, expected below %0d", cyc, MAXC);
      $fatal(1, "cycle budget exhausted");
    end
    sense = sense_arr[cyc];
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    cont = 1'b0;
    step(); step(); step();
    rst = 1'b0;
    last_n = '0;
    chk("rst_busy", 32'({busy_a, busy_b}), 32'd0);
    chk("rst_done", 32'({done_a, done_b}), 32'd0);
    chk("rst_ovf", 32'({ovf_a, ovf_b}), 32'd0);
    chk("rst_rd", 32'({rd_a, rd_b}), 32'd0);
  endtask

  task automatic read_all();
    rd_t r;
    for (int ch = 0; ch < 4; ch++) begin
      for (int b = 0; b < 2; b++) begin
        step();
        rd_ch = 2'(ch);
        rd_byte = 1'(b);
        r.at = cyc + 1;
        r.a = exp_byte(last_n, ch, b, 16);
        r.b = exp_byte(last_n, ch, b, 8);
        rd_q.push_back(r);
      end
    end
    step(); step();
  endtask

  // Issue start at the current cycle; nwin windows run back-to-back (cont high at all but the last LATCH).
  task automatic run_windows(input int w, input int nwin);
    int s, last, p;
    win_t e;
    s = cyc;
    for (int i = 0; i < nwin; i++) begin
      e.done_cyc = s + i * (w + 2) + 2 + w;
      for (int ch = 0; ch < NCH; ch++) e.n[ch] = 16'(edges(s + i * (w + 2), w, ch));
      exp_q.push_back(e);
    end
    last_n = e.n;
    last = s + nwin * (w + 2);
    p = w + 2;
    chk("busy_idle", 32'({busy_a, busy_b}), 32'd0);
    start = 1'b1;
    cont = 1'($urandom_range(0, 1));
    win_len = WIN_W'($urandom_range(0, 1023));
    rd_ch = 2'($urandom_range(0, 3));
    rd_byte = 1'($urandom_range(0, 1));
    for (int c = s + 1; c <= last; c++) begin
      step();
      start = 1'($urandom_range(0, 1));
      cont = 1'($urandom_range(0, 1));
      win_len = WIN_W'($urandom_range(0, 1023));
      if ((c - s) % p == 1) win_len = WIN_W'(w);
      if ((c - s) % p == 0) cont = ((c - s) / p < nwin) ? 1'b1 : 1'b0;
      if (c == s + 1) chk("busy_arm", 32'({busy_a, busy_b}), 32'd3);
    end
    step();
    start = 1'b0;
    cont = 1'b0;
    chk("busy_after_latch", 32'({busy_a, busy_b}), 32'd0);
  endtask

  // Monitor: done timing and latched results, plus readback responses.
  initial begin
    logic           pend;
    logic [NCH-1:0] p_oa, p_ob;
    logic [7:0]     p_ra, p_rb;
    win_t           e;
    rd_t            r;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (pend) begin
        chk("ovf_a", 32'(ovf_a), 32'(p_oa));
        chk("ovf_b", 32'(ovf_b), 32'(p_ob));
        chk("rd_after_done_a", 32'(rd_a), 32'(p_ra));
        chk("rd_after_done_b", 32'(rd_b), 32'(p_rb));
        pend = 1'b0;
      end
      if (exp_q.size() != 0 && exp_q[0].done_cyc < cyc) begin
        chk("done_missing", 32'(cyc), 32'(exp_q[0].done_cyc));
        void'(exp_q.pop_front());
      end
      if (done_a || done_b) begin
        if (exp_q.size() == 0) begin
          chk("spurious_done", 32'({done_a, done_b}), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("done_cycle", 32'(cyc), 32'(e.done_cyc));
          chk("done_pair", 32'({done_a, done_b}), 32'd3);
          p_oa = exp_ovf(e.n, 16);
          p_ob = exp_ovf(e.n, 8);
          p_ra = exp_byte(e.n, int'(rd_ch), int'(rd_byte), 16);
          p_rb = exp_byte(e.n, int'(rd_ch), int'(rd_byte), 8);
          pend = 1'b1;
        end
      end
      if (rd_q.size() != 0 && rd_q[0].at == cyc) begin
        r = rd_q.pop_front();
        chk($sformatf("rd_a_ch%0d_b%0d", rd_ch, rd_byte), 32'(rd_a), 32'(r.a));
        chk($sformatf("rd_b_ch%0d_b%0d", rd_ch, rd_byte), 32'(rd_b), 32'(r.b));
      end
    end
  end

  initial begin
    int i, len, w, s;
    i = 0;
    while (i < MAXC) begin
      len = $urandom_range(8, 200);
      for (int ch = 0; ch < NCH; ch++) fill(i, i + len - 1, ch, $urandom_range(0, 5));
      i += len;
    end
    rst = 1'b1; start = 1'b0; cont = 1'b0; win_len = '0;
    rd_ch = 2'd0; rd_byte = 1'b0; sense = '0;

    do_reset();
    read_all();

    // Single shot: ch0 at clk/4, ch1 tied low.
    s = cyc;
    fill(s + 1, s + 110, 0, 3);
    fill(s + 1, s + 110, 1, 0);
    run_windows(100, 1);
    read_all();

    // Saturation at clk/2 over 600 cycles, then a slow window clears overflow.
    s = cyc;
    for (int ch = 0; ch < NCH; ch++) fill(s + 1, s + 610, ch, 2);
    run_windows(600, 1);
    read_all();
    s = cyc;
    for (int ch = 0; ch < NCH; ch++) fill(s + 1, s + 110, ch, 4);
    run_windows(100, 1);
    read_all();

    run_windows(0, 1);
    read_all();

    run_windows(10, 4);
    read_all();

    // Reset halfway through a 100-cycle window: nothing may be latched.
    start = 1'b1;
    win_len = WIN_W'(100);
    for (int k = 0; k < 50; k++) begin
      step();
      start = 1'b0;
    end
    do_reset();
    read_all();
    run_windows(37, 1);
    read_all();

    for (int k = 0; k < 12; k++) begin
      w = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 5) : $urandom_range(6, 600);
      run_windows(w, $urandom_range(1, 3));
      read_all();
    end

    step(); step();
    chk("windows_outstanding", 32'(exp_q.size()), 32'd0);
    chk("reads_outstanding", 32'(rd_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
